// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch/jump redirects and data-memory waits.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_plus4,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic [31:0]      jump_target,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic [31:0]      NPC,
    output logic             Load_use_Flag,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             memwb_bubble,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        ST_RUN,
        ST_MEM_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;

    logic lu_c;
    logic mem_miss_c;
    logic memstall_c;

    // A load in EX whose destination is read by the instruction in ID.
    assign lu_c = ex_mem_read && (ex_rd != 5'd0) &&
                  ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    assign mem_miss_c = dmem_req && !dmem_ready;
    assign memstall_c = (state_q == ST_MEM_WAIT) || mem_miss_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    // Wait tracking; a timeout releases the pipeline and latches the sticky error.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_miss_c) begin
                    state_d = ST_MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q >= WCNT_W'(MEM_TIMEOUT)) begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                    err_d   = 1'b1;
                end else if (wcnt_q != '1) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // Zero-latency control decode; everything is forced idle while rst is high.
    always_comb begin
        NPC           = pc_plus4;
        Load_use_Flag = 1'b0;
        ifid_hold     = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_hold    = 1'b0;
        memwb_bubble  = 1'b0;
        if (!rst) begin
            if (memstall_c) begin
                Load_use_Flag = 1'b1;
                ifid_hold     = 1'b1;
                exmem_hold    = 1'b1;
                memwb_bubble  = 1'b1;
            end else if (ex_branch_taken) begin
                NPC        = branch_target;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu_c) begin
                Load_use_Flag = 1'b1;
                ifid_hold     = 1'b1;
                idex_flush    = 1'b1;
            end else if (id_jump) begin
                NPC        = jump_target;
                ifid_flush = 1'b1;
            end
        end
    end

    assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // Every redirect (branch or jump) is exactly the set of cycles that flush IF/ID.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (Load_use_Flag && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (ifid_flush && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected control vectors are queued per driven cycle
// and compared against the DUT outputs on the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MEM_TIMEOUT = 64;
    localparam int unsigned CNT_W       = 32;

    // {Load_use_Flag, ifid_hold, ifid_flush, idex_flush, exmem_hold, memwb_bubble}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110100;
    localparam logic [5:0] C_BR   = 6'b001100;
    localparam logic [5:0] C_JMP  = 6'b001000;
    localparam logic [5:0] C_MEM  = 6'b110011;

    logic             clk;
    logic             rst;
    logic [31:0]      pc_plus4;
    logic [4:0]       id_rs, id_rt;
    logic             id_uses_rs, id_uses_rt, id_jump;
    logic [31:0]      jump_target;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic [31:0]      branch_target;
    logic             dmem_req, dmem_ready;
    logic [31:0]      NPC;
    logic             Load_use_Flag, ifid_hold, ifid_flush, idex_flush;
    logic             exmem_hold, memwb_bubble, mem_timeout_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    typedef struct packed {
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic        jmp;
        logic [31:0] jt;
        logic        mr;
        logic [4:0]  rd;
        logic        bt;
        logic [31:0] btg;
        logic        req;
        logic        rdy;
    } stim_t;

    typedef struct packed {
        logic [31:0] npc;
        logic [5:0]  ctrl;
        logic        err;
    } obs_t;

    obs_t        exp_q[$];
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
    logic        m_err   = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_plus4       (pc_plus4),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_jump        (id_jump),
        .jump_target    (jump_target),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .branch_target  (branch_target),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .NPC            (NPC),
        .Load_use_Flag  (Load_use_Flag),
        .ifid_hold      (ifid_hold),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_hold     (exmem_hold),
        .memwb_bubble   (memwb_bubble),
        .mem_timeout_err(mem_timeout_err),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.pc4 = 32'h0000_1000 + 32'($urandom_range(0, 255)) * 32'd4;
        s.jt  = 32'h0000_0080;
        s.btg = 32'h0000_0040;
        s.rs  = 5'd1;
        s.rt  = 5'd2;
        s.rd  = 5'd3;
        return s;
    endfunction

    function automatic obs_t mk(input logic [31:0] npc, input logic [5:0] ctrl);
        obs_t o;
        o.npc  = npc;
        o.ctrl = ctrl;
        o.err  = m_err;
        return o;
    endfunction

    function automatic obs_t outs();
        obs_t o;
        o = {NPC, Load_use_Flag, ifid_hold, ifid_flush, idex_flush, exmem_hold, memwb_bubble,
             mem_timeout_err};
        return o;
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt(input int unsigned v);
`ifdef HAZARD_PERF_CNT_EN
        return CNT_W'(v);
`else
        return CNT_W'(v & 0);
`endif
    endfunction

    task automatic apply(input stim_t s);
        pc_plus4        = s.pc4;
        id_rs           = s.rs;
        id_rt           = s.rt;
        id_uses_rs      = s.urs;
        id_uses_rt      = s.urt;
        id_jump         = s.jmp;
        jump_target     = s.jt;
        ex_mem_read     = s.mr;
        ex_rd           = s.rd;
        ex_branch_taken = s.bt;
        branch_target   = s.btg;
        dmem_req        = s.req;
        dmem_ready      = s.rdy;
    endtask

    // Queue the expectation and advance the counter model; reset clears it.
    task automatic push_exp(input obs_t e);
        exp_q.push_back(e);
        if (rst) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (e.ctrl[5]) m_stall++;
            if (e.ctrl[3]) m_flush++;
        end
    endtask

    task automatic test_reset();
        stim_t s;
        obs_t  got, want;
        for (int i = 0; i < 2; i++) begin
            s = idle();
            if (i == 0) begin
                rst   = 1'b1;
                s.req = 1'b1;
                s.bt  = 1'b1;
            end
            apply(s);
            push_exp(mk(s.pc4, C_NONE));
            @(negedge clk);
            got  = outs();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", i, got, want);
            end
            if (i == 0) begin
                n_checks++;
                if (stall_cycles !== '0 || flush_count !== '0) begin
                    n_fail++;
                    $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_count);
                end
            end
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    task automatic test_load_use();
        stim_t s;
        obs_t  e, got, want;
        for (int i = 0; i < 4; i++) begin
            s = idle();
            case (i)
                0: begin s.mr = 1; s.rd = 5'd9; s.rs = 5'd9; s.urs = 1; e = mk(s.pc4, C_LU); end
                2: begin
                    s.mr = 1; s.rd = 5'd7; s.rt = 5'd7; s.urt = 1; s.rs = 5'd9; s.urs = 1;
                    e = mk(s.pc4, C_LU);
                end
                default: e = mk(s.pc4, C_NONE);
            endcase
            apply(s);
            push_exp(e);
            @(negedge clk);
            got  = outs();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL load_use cyc=%0d got=%h exp=%h", i, got, want);
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (stall_cycles !== exp_cnt(m_stall)) begin
            n_fail++;
            $display("FAIL load_use_stall_cnt got=%0d exp=%0d", stall_cycles, exp_cnt(m_stall));
        end
    endtask

    task automatic test_no_stall();
        stim_t s;
        obs_t  got, want;
        for (int i = 0; i < 4; i++) begin
            s = idle();
            case (i)
                0: begin s.mr = 1; s.rd = 5'd0; s.rs = 5'd0; s.urs = 1; s.rt = 5'd0; s.urt = 1; end
                1: begin s.mr = 1; s.rd = 5'd5; s.rt = 5'd5; s.urt = 0; s.rs = 5'd3; s.urs = 1; end
                2: begin s.mr = 1; s.rd = 5'd5; s.rs = 5'd5; s.urs = 0; s.rt = 5'd5; s.urt = 0; end
                default: begin s.mr = 0; s.rd = 5'd5; s.rs = 5'd5; s.urs = 1; end
            endcase
            apply(s);
            push_exp(mk(s.pc4, C_NONE));
            @(negedge clk);
            got  = outs();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL no_stall cyc=%0d got=%h exp=%h", i, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch_jump();
        stim_t s;
        obs_t  e, got, want;
        for (int i = 0; i < 5; i++) begin
            s = idle();
            case (i)
                0: begin s.bt = 1; s.jmp = 1; e = mk(32'h40, C_BR); end
                1: begin s.jmp = 1; s.jt = 32'h0040_0000 + s.pc4; e = mk(s.jt, C_JMP); end
                2: begin
                    s.bt = 1; s.mr = 1; s.rd = 5'd9; s.rs = 5'd9; s.urs = 1;
                    e = mk(32'h40, C_BR);
                end
                3: begin
                    s.jmp = 1; s.mr = 1; s.rd = 5'd9; s.rs = 5'd9; s.urs = 1;
                    e = mk(s.pc4, C_LU);
                end
                default: e = mk(s.pc4, C_NONE);
            endcase
            apply(s);
            push_exp(e);
            @(negedge clk);
            got  = outs();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL branch_jump cyc=%0d got=%h exp=%h", i, got, want);
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (flush_count !== exp_cnt(m_flush)) begin
            n_fail++;
            $display("FAIL flush_cnt got=%0d exp=%0d", flush_count, exp_cnt(m_flush));
        end
    endtask

    task automatic test_mem_wait();
        stim_t s;
        obs_t  e, got, want;
        for (int i = 0; i < 7; i++) begin
            s = idle();
            case (i)
                0: begin s.req = 1; s.bt = 1; s.jmp = 1; e = mk(s.pc4, C_MEM); end
                1, 2: begin
                    s.req = 1; s.mr = 1; s.rd = 5'd9; s.rs = 5'd9; s.urs = 1;
                    e = mk(s.pc4, C_MEM);
                end
                3: begin s.req = 1; s.rdy = 1; e = mk(s.pc4, C_MEM); end
                5: begin s.req = 1; s.rdy = 1; s.jmp = 1; e = mk(s.jt, C_JMP); end
                default: e = mk(s.pc4, C_NONE);
            endcase
            apply(s);
            push_exp(e);
            @(negedge clk);
            got  = outs();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL mem_wait cyc=%0d got=%h exp=%h", i, got, want);
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (stall_cycles !== exp_cnt(m_stall) || flush_count !== exp_cnt(m_flush)) begin
            n_fail++;
            $display("FAIL mem_wait_counters got=%0d/%0d exp=%0d/%0d", stall_cycles, flush_count,
                     exp_cnt(m_stall), exp_cnt(m_flush));
        end
    endtask

    task automatic test_timeout();
        stim_t s;
        obs_t  e, got, want;
        for (int i = 0; i <= int'(MEM_TIMEOUT) + 3; i++) begin
            s = idle();
            if (i <= int'(MEM_TIMEOUT)) begin
                s.req = 1;
                e     = mk(s.pc4, C_MEM);
            end else if (i == int'(MEM_TIMEOUT) + 1) begin
                m_err = 1'b1;
                e     = mk(s.pc4, C_NONE);
            end else if (i == int'(MEM_TIMEOUT) + 2) begin
                s.mr = 1; s.rd = 5'd4; s.rt = 5'd4; s.urt = 1;
                e    = mk(s.pc4, C_LU);
            end else begin
                rst   = 1'b1;
                m_err = 1'b0;
                e     = mk(s.pc4, C_NONE);
            end
            apply(s);
            push_exp(e);
            @(negedge clk);
            got  = outs();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL timeout cyc=%0d got=%h exp=%h", i, got, want);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_rst_mid_wait();
        stim_t s;
        obs_t  e, got, want;
        for (int i = 0; i < 5; i++) begin
            s = idle();
            case (i)
                0, 1: begin s.req = 1; e = mk(s.pc4, C_MEM); end
                2: begin s.req = 1; s.bt = 1; e = mk(s.pc4, C_NONE); end
                3: begin s.mr = 1; s.rd = 5'd9; s.rs = 5'd9; s.urs = 1; e = mk(s.pc4, C_LU); end
                default: e = mk(s.pc4, C_NONE);
            endcase
            apply(s);
            if (i == 2) begin
                rst = 1'b1;
                push_exp(e);
                #1;
                got  = outs();
                want = exp_q.pop_front();
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL rst_mid_wait_async got=%h exp=%h", got, want);
                end
                n_checks++;
                if (stall_cycles !== '0 || flush_count !== '0) begin
                    n_fail++;
                    $display("FAIL rst_mid_wait_counters got=%0d/%0d exp=0/0", stall_cycles,
                             flush_count);
                end
                @(negedge clk);
                dmem_req = 1'b0;
                rst      = 1'b0;
            end else begin
                push_exp(e);
                @(negedge clk);
                got  = outs();
                want = exp_q.pop_front();
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL rst_mid_wait cyc=%0d got=%h exp=%h", i, got, want);
                end
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (stall_cycles !== exp_cnt(m_stall)) begin
            n_fail++;
            $display("FAIL post_rst_stall_cnt got=%0d exp=%0d", stall_cycles, exp_cnt(m_stall));
        end
    endtask

    initial begin
        rst = 1'b1;
        apply(idle());
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_jump();
        test_mem_wait();
        test_timeout();
        test_rst_mid_wait();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
